// File: rtl/store_unit.sv
// Store unit: turns a converted store into one word-aligned req/ack bus write.
// Optional macro STORE_UNIT_SPLIT_EN performs stores that cross a word boundary as two beats.
module store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] ir,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        misalign,
    output logic        buserr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wrdata,
    output logic [3:0]  mem_wrbits,
    input  logic        mem_ack
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_DONE,
        S_ERR
`ifdef STORE_UNIT_SPLIT_EN
        , S_GAP
        , S_REQ2
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [2:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        bus_q, bus_d;

    logic [3:0]  mask;
    logic [7:0]  m8;
    logic [31:0] rot;
    logic [31:0] word;
    logic        tmo;
    logic        start_mis;
    logic        unused_bits;

    assign unused_bits = ^{ir[31:15], ir[11:0], m8[7:4]};

    always_comb begin
        mask = 4'b1111;
        unique case (size_q)
            3'b000:  mask = 4'b0001;
            3'b001:  mask = 4'b0011;
            default: mask = 4'b1111;
        endcase
    end

    assign m8   = {4'b0000, mask} << addr_q[1:0];
    assign word = {addr_q[31:2], 2'b00};
    assign tmo  = (TIMEOUT != 0) && (cnt_q == TIMEOUT - 32'd1);

    // Checked on the live inputs so the first state after IDLE is already right.
    assign start_mis = ((ir[14:12] == 3'b001) && addr[0]) ||
                       ((ir[14:12] != 3'b000) && (ir[14:12] != 3'b001) &&
                        (addr[1:0] != 2'b00));

    always_comb begin
        rot = wdata_q;
        unique case (addr_q[1:0])
            2'd0: rot = wdata_q;
            2'd1: rot = {wdata_q[23:0], wdata_q[31:24]};
            2'd2: rot = {wdata_q[15:0], wdata_q[31:16]};
            2'd3: rot = {wdata_q[7:0],  wdata_q[31:8]};
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        bus_d   = bus_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    size_d  = ir[14:12];
                    addr_d  = addr;
                    wdata_d = wdata;
                    bus_d   = 1'b0;
                    cnt_d   = '0;
`ifdef STORE_UNIT_SPLIT_EN
                    state_d = S_REQ;
`else
                    state_d = start_mis ? S_ERR : S_REQ;
`endif
                end
            end
            S_REQ: begin
                if (mem_ack) begin
`ifdef STORE_UNIT_SPLIT_EN
                    state_d = (m8[7:4] != 4'b0000) ? S_GAP : S_DONE;
`else
                    state_d = S_DONE;
`endif
                end else if (tmo) begin
                    state_d = S_ERR;
                    bus_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
`ifdef STORE_UNIT_SPLIT_EN
            S_GAP: begin
                cnt_d   = '0;
                state_d = S_REQ2;
            end
            S_REQ2: begin
                if (mem_ack) begin
                    state_d = S_DONE;
                end else if (tmo) begin
                    state_d = S_ERR;
                    bus_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            bus_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            bus_q   <= bus_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE) || (state_q == S_ERR);
    assign buserr     = (state_q == S_ERR) && bus_q;
    assign mem_wrdata = rot;

`ifdef STORE_UNIT_SPLIT_EN
    assign misalign   = 1'b0;
    assign mem_req    = (state_q == S_REQ) || (state_q == S_REQ2);
    assign mem_addr   = (state_q == S_REQ2) ? word + 32'd4 : word;
    assign mem_wrbits = (state_q == S_REQ)  ? m8[3:0] :
                        (state_q == S_REQ2) ? m8[7:4] : 4'b0000;
`else
    assign misalign   = (state_q == S_ERR) && !bus_q;
    assign mem_req    = (state_q == S_REQ);
    assign mem_addr   = word;
    assign mem_wrbits = (state_q == S_REQ) ? m8[3:0] : 4'b0000;
`endif

endmodule

// File: tb/tb_store_unit.sv
// Scoreboard bench for store_unit: byte-level reference model, random and directed stores.
module tb_store_unit;

    localparam int TO = 6;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] ir = '0, addr = '0, wdata = '0;
    logic        busy, done, misalign, buserr, mem_req, mem_ack = 1'b0;
    logic [31:0] mem_addr, mem_wrdata;
    logic [3:0]  mem_wrbits;

    store_unit #(.TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .start(start), .ir(ir),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done),
        .misalign(misalign), .buserr(buserr), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_wrdata(mem_wrdata),
        .mem_wrbits(mem_wrbits), .mem_ack(mem_ack)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [3:0]  bits;
        logic [31:0] d;
    } beat_t;

    typedef struct {
        logic mis;
        logic berr;
    } fin_t;

    beat_t beat_q[$];
    fin_t  fin_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: each store byte k lands at byte address a+k, grouped by word.
    task automatic model(input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] d, input int d0, input int d1,
                         output int lat);
        int n, off, nb, dl, src;
        logic [7:0]  touched;
        logic [31:0] data;
        logic        mis;
        beat_t       b;
        n   = (f == 3'd0) ? 1 : (f == 3'd1) ? 2 : 4;
        off = int'(a[1:0]);
        touched = '0;
        for (int k = 0; k < n; k++) touched[off + k] = 1'b1;
        for (int j = 0; j < 4; j++) begin
            src = (j - off + 4) % 4;
            data[8*j +: 8] = d[8*src +: 8];
        end
        mis = (off % n) != 0;
`ifdef STORE_UNIT_SPLIT_EN
        mis = 1'b0;
`endif
        lat = 1;
        if (mis) begin
            fin_q.push_back('{1'b1, 1'b0});
            return;
        end
        nb = (touched[7:4] != 4'b0000) ? 2 : 1;
        for (int i = 0; i < nb; i++) begin
            b.a    = {a[31:2], 2'b00} + 32'(4 * i);
            b.bits = touched[4*i +: 4];
            b.d    = data;
            beat_q.push_back(b);
            dl = (i == 0) ? d0 : d1;
            if (dl >= TO) begin
                lat += TO;
                fin_q.push_back('{1'b0, 1'b1});
                return;
            end
            lat += dl + 1;
            if (i < nb - 1) lat += 1;
        end
        fin_q.push_back('{1'b0, 1'b0});
    endtask

    // Monitor
    logic  prev_req = 1'b0;
    beat_t cur;
    always @(negedge clock) begin
        if (!reset) begin
            prev_req = 1'b0;
        end else begin
            if (mem_req && !prev_req) begin
                if (beat_q.size() == 0) begin
                    chk("unexpected_beat", {31'd0, mem_req}, 32'd0);
                end else begin
                    cur = beat_q.pop_front();
                    chk("mem_addr", mem_addr, cur.a);
                    chk("mem_wrbits", {28'd0, mem_wrbits}, {28'd0, cur.bits});
                    chk("mem_wrdata", mem_wrdata, cur.d);
                end
            end else if (mem_req) begin
                chk("hold_addr", mem_addr, cur.a);
                chk("hold_bits", {28'd0, mem_wrbits}, {28'd0, cur.bits});
                chk("hold_data", mem_wrdata, cur.d);
            end else begin
                chk("wrbits_noreq", {28'd0, mem_wrbits}, 32'd0);
            end
            if (done) begin
                if (fin_q.size() == 0) begin
                    chk("unexpected_done", {31'd0, done}, 32'd0);
                end else begin
                    fin_t e;
                    e = fin_q.pop_front();
                    chk("misalign", {31'd0, misalign}, {31'd0, e.mis});
                    chk("buserr", {31'd0, buserr}, {31'd0, e.berr});
                end
            end
            prev_req = mem_req;
        end
    end

    task automatic do_store(input logic [2:0] f, input logic [31:0] a,
                            input logic [31:0] d, input int d0, input int d1);
        int exp_lat, lat, bi, w;
        int dly[2];
        bit fin;
        dly[0] = d0;
        dly[1] = d1;
        model(f, a, d, d0, d1, exp_lat);
        @(negedge clock);
        ir = $urandom;
        ir[14:12] = f;
        addr = a;
        wdata = d;
        start = 1'b1;
        mem_ack = 1'b0;
        lat = 0; bi = 0; w = 0; fin = 1'b0;
        while (!fin) begin
            @(negedge clock);
            lat++;
            start = 1'b0;
            chk("busy", {31'd0, busy}, 32'd1);
            if (done) begin
                fin = 1'b1;
                chk("latency", lat, exp_lat);
            end else if (lat > 100) begin
                fin = 1'b1;
                chk("done_timeout", 32'd0, 32'd1);
            end else begin
                if (mem_req) begin
                    if (dly[bi] < TO && w == dly[bi]) begin
                        mem_ack = 1'b1;
                        bi = (bi == 0) ? 1 : 1;
                        w = 0;
                    end else begin
                        mem_ack = 1'b0;
                        w++;
                    end
                end else begin
                    mem_ack = 1'($urandom);
                end
                start = busy && ($urandom_range(0, 5) == 0);
                ir = $urandom;
                addr = $urandom;
                wdata = $urandom;
            end
        end
        mem_ack = 1'b0;
        start = 1'b0;
    endtask

    task automatic do_reset_mid();
        int lat;
        model(3'b010, 32'h0000_4000, 32'hCAFE_F00D, TO, TO, lat);
        @(negedge clock);
        ir = '0;
        ir[14:12] = 3'b010;
        addr = 32'h0000_4000;
        wdata = 32'hCAFE_F00D;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("req_before_reset", {31'd0, mem_req}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_wrbits", {28'd0, mem_wrbits}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        beat_q.delete();
        fin_q.delete();
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        #12;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_req", {31'd0, mem_req}, 32'd0);
        chk("reset_flags", {30'd0, misalign, buserr}, 32'd0);
        chk("reset_data", mem_wrdata, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        do_store(3'b000, 32'h0000_1003, 32'h5A5A_5A5A, 0, 0);
        do_store(3'b001, 32'h0000_2002, 32'hBEEF_BEEF, TO - 1, 0);
        do_store(3'b010, 32'h0000_3001, 32'h1122_3344, 0, 0);
        do_store(3'b010, 32'h0000_3001, 32'h1122_3344, 2, TO);
        do_store(3'b010, 32'h0000_5000, 32'h0BAD_0BAD, TO, 0);
        do_store(3'b001, 32'hFFFF_FFFF, 32'h1234_1234, 1, 1);
        do_reset_mid();
        do_store(3'b010, 32'h0000_6000, 32'h8765_4321, 1, 0);

        for (int i = 0; i < 300; i++) begin
            int r0, r1;
            r0 = $urandom_range(0, 15);
            r1 = $urandom_range(0, 15);
            do_store(3'($urandom), $urandom, $urandom,
                     (r0 < 13) ? r0 % TO : TO, (r1 < 13) ? r1 % TO : TO);
        end

        repeat (3) @(negedge clock);
        chk("beats_left", beat_q.size(), 32'd0);
        chk("dones_left", fin_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
